// File: rtl/vco_meas_seq_if.sv
// ----------------------------------------------------------------------------
// vco_meas_seq_if
// Groups the control, configuration, PAD_OUT sense and result signals that
// connect the VCO_full measurement sequencer to its surroundings.
//
//   slave  (sequencer side): inputs  start, abort, div_sel_cfg, gate_cyc,
//                                    pad_out
//                            outputs vco_resetb, vco_load, vco_div_sel,
//                                    en_vco, clk_kill, busy, done, count, ovf
//   master (controller side): the same signals with opposite directions
// ----------------------------------------------------------------------------
interface vco_meas_seq_if #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
) ();
    logic              start;
    logic              abort;
    logic [1:0]        div_sel_cfg;
    logic [GATE_W-1:0] gate_cyc;
    logic              pad_out;
    logic              vco_resetb;
    logic              vco_load;
    logic [1:0]        vco_div_sel;
    logic              en_vco;
    logic              clk_kill;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    modport slave (
        input  start, abort, div_sel_cfg, gate_cyc, pad_out,
        output vco_resetb, vco_load, vco_div_sel, en_vco, clk_kill,
               busy, done, count, ovf
    );

    modport master (
        output start, abort, div_sel_cfg, gate_cyc, pad_out,
        input  vco_resetb, vco_load, vco_div_sel, en_vco, clk_kill,
               busy, done, count, ovf
    );
endinterface

// File: rtl/vco_meas_seq.sv
// ----------------------------------------------------------------------------
// vco_meas_seq
// Sequencer and frequency meter for the VCO_full odometer macro. Drives the
// VCO reset / load / enable / clock-kill controls in the order the macro needs
// and counts PAD_OUT rising edges over a programmable gate window.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      vco_meas_seq_if.slave: run request, abort, divider select,
//            gate length, PAD_OUT in; VCO controls, BUSY, DONE, COUNT, OVF out
// ----------------------------------------------------------------------------
module vco_meas_seq #(
    parameter int GATE_W     = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 32,
    parameter int RST_CYC    = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    vco_meas_seq_if.slave  bus
);
    // One shared down-counter times RST, SETTLE, GATE and KILL, so it must be
    // wide enough for the largest of them.
    localparam int W_S   = $clog2(SETTLE_CYC + 1);
    localparam int W_R   = $clog2(RST_CYC + 1);
    localparam int W_SR  = (W_S > W_R) ? W_S : W_R;
    localparam int TMR_W = (GATE_W > W_SR) ? GATE_W : W_SR;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_CFG, S_SETTLE, S_GATE, S_KILL, S_DONE
    } state_t;

    state_t            r_state;
    logic [TMR_W-1:0]  r_tmr;
    logic [GATE_W-1:0] r_gate;
    logic [1:0]        r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_vco_resetb;
    logic              r_vco_load;
    logic [1:0]        r_vco_div_sel;
    logic              r_en_vco;
    logic              r_clk_kill;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf_out;

    // PAD_OUT is asynchronous: two-flop synchronizer plus an edge-detect flop.
    logic r_sync1, r_sync2, r_prev;
    logic w_edge;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= bus.pad_out;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;

    logic w_tmr_zero;
    logic w_abort_ok;
    logic w_kill_now;

    assign w_tmr_zero = (r_tmr == '0);
    assign w_abort_ok = bus.abort && ((r_state == S_RST) || (r_state == S_CFG) ||
                                      (r_state == S_SETTLE) || (r_state == S_GATE));
    // Every route into KILL (abort, empty gate, gate expiry) is collected here
    // so the kill entry is written once, after the per-state logic.
    assign w_kill_now = w_abort_ok ||
                        ((r_state == S_SETTLE) && w_tmr_zero && (r_gate == '0)) ||
                        ((r_state == S_GATE) && w_tmr_zero);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_gate        <= '0;
            r_div         <= 2'b11;
            r_cnt         <= '0;
            r_ovf         <= 1'b0;
            r_vco_resetb  <= 1'b0;
            r_vco_load    <= 1'b0;
            r_vco_div_sel <= 2'b11;
            r_en_vco      <= 1'b0;
            r_clk_kill    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_count       <= '0;
            r_ovf_out     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_vco_resetb <= 1'b1;
                    if (bus.start) begin
                        r_gate       <= bus.gate_cyc;
                        r_div        <= bus.div_sel_cfg;
                        r_cnt        <= '0;
                        r_ovf        <= 1'b0;
                        r_tmr        <= TMR_W'(RST_CYC - 1);
                        r_vco_resetb <= 1'b0;
                        r_clk_kill   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_RST;
                    end
                end
                S_RST: begin
                    if (w_tmr_zero) begin
                        r_vco_resetb  <= 1'b1;
                        r_vco_div_sel <= r_div;
                        r_en_vco      <= 1'b1;
                        r_vco_load    <= 1'b0;
                        r_state       <= S_CFG;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_CFG: begin
                    r_vco_load <= 1'b1;
                    r_tmr      <= TMR_W'(SETTLE_CYC - 1);
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (w_tmr_zero) begin
                        r_tmr   <= TMR_W'(r_gate) - TMR_W'(1);
                        r_state <= S_GATE;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_GATE: begin
                    // Saturating count; an edge arriving while saturated flags OVF.
                    if (w_edge) begin
                        if (&r_cnt) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    r_tmr <= r_tmr - TMR_W'(1);
                end
                S_KILL: begin
                    if (w_tmr_zero) begin
                        r_done    <= 1'b1;
                        r_count   <= r_cnt;
                        r_ovf_out <= r_ovf;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Overrides the per-state next values above.
            if (w_kill_now) begin
                r_clk_kill <= 1'b1;
                r_en_vco   <= 1'b0;
                r_vco_load <= 1'b0;
                r_tmr      <= TMR_W'(1);
                r_state    <= S_KILL;
            end
        end
    end

    assign bus.vco_resetb  = r_vco_resetb;
    assign bus.vco_load    = r_vco_load;
    assign bus.vco_div_sel = r_vco_div_sel;
    assign bus.en_vco      = r_en_vco;
    assign bus.clk_kill    = r_clk_kill;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.count       = r_count;
    assign bus.ovf         = r_ovf_out;
endmodule
